// File: rtl/rename_alloc_ctrl.sv
// rtl/rename_alloc_ctrl.sv - rename-stage preg allocator between decode and the free list
// Packs free-list pregs onto the slots of a decode bundle that need a destination.
module rename_alloc_ctrl #(
  parameter int NSLOT = 4,
  parameter int PW    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dec_valid,
  input  logic [NSLOT-1:0] i_dec_need,
  output logic             o_dec_ready,
  input  logic [PW-1:0]    i_fl_avail,
  input  logic [PW-1:0]    i_fl_req0,
  input  logic [PW-1:0]    i_fl_req1,
  input  logic [PW-1:0]    i_fl_req2,
  input  logic [PW-1:0]    i_fl_req3,
  output logic [2:0]       o_fl_req_count,
  output logic             o_ren_valid,
  output logic [NSLOT-1:0] o_ren_mask,
  output logic [PW-1:0]    o_ren_preg0,
  output logic [PW-1:0]    o_ren_preg1,
  output logic [PW-1:0]    o_ren_preg2,
  output logic [PW-1:0]    o_ren_preg3,
  input  logic             i_ren_ready,
  input  logic             i_flush,
  output logic [15:0]      o_stall_cycles
);

  typedef enum logic [1:0] {INIT, RUN, STALL, FLUSH} state_t;

  state_t          r_state;
  logic            r_init_cnt;
  logic            r_ren_valid;
  logic [NSLOT-1:0] r_ren_mask;
  logic [PW-1:0]   r_preg [NSLOT];
  logic [15:0]     r_stall_cycles;

  logic [PW-1:0]   w_req [4];
  logic [PW-1:0]   w_slot_preg [NSLOT];
  logic [2:0]      w_n;
  logic [2:0]      w_k;
  logic            w_out_free;
  logic            w_fits;
  logic            w_active;
  logic            w_accept;

  assign w_req[0] = i_fl_req0;
  assign w_req[1] = i_fl_req1;
  assign w_req[2] = i_fl_req2;
  assign w_req[3] = i_fl_req3;

  always_comb begin
    w_n = 3'd0;
    for (int i = 0; i < NSLOT; i++) w_n = w_n + {2'b00, i_dec_need[i]};
  end

  // k-th needing slot (counting from slot 0) takes the k-th lowest free preg
  always_comb begin
    w_k = 3'd0;
    for (int i = 0; i < NSLOT; i++) begin
      w_slot_preg[i] = '0;
      if (i_dec_need[i]) begin
        w_slot_preg[i] = w_req[w_k[1:0]];
        w_k = w_k + 3'd1;
      end
    end
  end

  assign w_out_free     = !r_ren_valid || i_ren_ready;
  assign w_fits         = {{(PW-3){1'b0}}, w_n} <= i_fl_avail;
  assign w_active       = (r_state == RUN) || (r_state == STALL);
  assign o_dec_ready    = w_active && w_out_free && w_fits && !i_flush && !i_rst;
  assign w_accept       = i_dec_valid && o_dec_ready;
  assign o_fl_req_count = w_accept ? w_n : 3'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= INIT;
      r_init_cnt     <= 1'b1;
      r_ren_valid    <= 1'b0;
      r_ren_mask     <= '0;
      r_stall_cycles <= 16'd0;
      for (int i = 0; i < NSLOT; i++) r_preg[i] <= '0;
    end else begin
      if (r_state == STALL && r_stall_cycles != 16'hFFFF)
        r_stall_cycles <= r_stall_cycles + 16'd1;

      case (r_state)
        INIT: begin
          if (r_init_cnt == 1'b0) r_state <= RUN;
          r_init_cnt <= 1'b0;
        end
        RUN: begin
          if (i_flush) r_state <= FLUSH;
          else if (i_dec_valid && !w_fits && w_out_free) r_state <= STALL;
        end
        STALL: begin
          if (i_flush) r_state <= FLUSH;
          else if (w_accept || !i_dec_valid) r_state <= RUN;
        end
        FLUSH: begin
          if (!i_flush) r_state <= RUN;
        end
        default: r_state <= INIT;
      endcase

      // flushed pregs are simply dropped; the commit path reclaims them
      if (i_flush && r_state != INIT) begin
        r_ren_valid <= 1'b0;
      end else if (w_accept) begin
        r_ren_valid <= 1'b1;
        r_ren_mask  <= i_dec_need;
        for (int i = 0; i < NSLOT; i++) r_preg[i] <= w_slot_preg[i];
      end else if (w_out_free) begin
        r_ren_valid <= 1'b0;
      end
    end
  end

  assign o_ren_valid    = r_ren_valid;
  assign o_ren_mask     = r_ren_mask;
  assign o_ren_preg0    = r_preg[0];
  assign o_ren_preg1    = r_preg[1];
  assign o_ren_preg2    = r_preg[2];
  assign o_ren_preg3    = r_preg[3];
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb/tb_rename_alloc_ctrl.sv - scoreboard bench for rename_alloc_ctrl
module tb_rename_alloc_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_dec_valid;
  logic [3:0] i_dec_need;
  logic       o_dec_ready;
  logic [5:0] i_fl_avail;
  logic [5:0] i_fl_req0, i_fl_req1, i_fl_req2, i_fl_req3;
  logic [2:0] o_fl_req_count;
  logic       o_ren_valid;
  logic [3:0] o_ren_mask;
  logic [5:0] o_ren_preg0, o_ren_preg1, o_ren_preg2, o_ren_preg3;
  logic       i_ren_ready;
  logic       i_flush;
  logic [15:0] o_stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [27:0] sb_q[$];

  rename_alloc_ctrl #(.NSLOT(4), .PW(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_dec_valid(i_dec_valid), .i_dec_need(i_dec_need), .o_dec_ready(o_dec_ready),
    .i_fl_avail(i_fl_avail),
    .i_fl_req0(i_fl_req0), .i_fl_req1(i_fl_req1), .i_fl_req2(i_fl_req2), .i_fl_req3(i_fl_req3),
    .o_fl_req_count(o_fl_req_count),
    .o_ren_valid(o_ren_valid), .o_ren_mask(o_ren_mask),
    .o_ren_preg0(o_ren_preg0), .o_ren_preg1(o_ren_preg1),
    .o_ren_preg2(o_ren_preg2), .o_ren_preg3(o_ren_preg3),
    .i_ren_ready(i_ren_ready), .i_flush(i_flush), .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [3:0] m, input logic [5:0] p0, input logic [5:0] p1,
                      input logic [5:0] p2, input logic [5:0] p3);
    sb_q.push_back({m, p0, p1, p2, p3});
    n_pushed++;
  endtask

  task automatic set_reqs(input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] c, input logic [5:0] d);
    i_fl_req0 = a; i_fl_req1 = b; i_fl_req2 = c; i_fl_req3 = d;
  endtask

  // a bundle leaves the output register when valid && ready at the sampling edge
  always @(negedge i_clk) begin
    if (o_ren_valid && i_ren_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_bundle", 32'd1, 32'd0);
      end else begin
        chk("sb_bundle", {4'd0, o_ren_mask, o_ren_preg0, o_ren_preg1, o_ren_preg2, o_ren_preg3},
            {4'd0, sb_q.pop_front()});
        n_popped++;
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_dec_valid = 1'b0; i_dec_need = 4'd0; i_fl_avail = 6'd0;
    set_reqs(6'd0, 6'd0, 6'd0, 6'd0);
    i_ren_ready = 1'b1; i_flush = 1'b0;
    step();
    i_rst = 1'b0;

    // reset values and 2-cycle INIT with a bundle already waiting
    i_fl_avail = 6'd48; i_dec_valid = 1'b1; i_dec_need = 4'b1111;
    set_reqs(6'd0, 6'd1, 6'd2, 6'd3);
    settle();
    chk("rst_valid", o_ren_valid, 1'b0);
    chk("rst_mask", o_ren_mask, 4'd0);
    chk("rst_preg0", o_ren_preg0, 6'd0);
    chk("rst_stall", o_stall_cycles, 16'd0);
    chk("init1_ready", o_dec_ready, 1'b0);
    chk("init1_cnt", o_fl_req_count, 3'd0);
    step();
    chk("init2_ready", o_dec_ready, 1'b0);
    chk("init2_cnt", o_fl_req_count, 3'd0);
    step();
    chk("run_ready", o_dec_ready, 1'b1);
    chk("run_cnt4", o_fl_req_count, 3'd4);
    push(4'b1111, 6'd0, 6'd1, 6'd2, 6'd3);
    step();
    chk("lat1_valid", o_ren_valid, 1'b1);

    // sparse need: pregs land on the needing slots in order
    i_dec_need = 4'b1010; set_reqs(6'd5, 6'd6, 6'd7, 6'd8);
    settle();
    chk("sparse_cnt", o_fl_req_count, 3'd2);
    push(4'b1010, 6'd0, 6'd5, 6'd0, 6'd6);
    step();

    // resource stall: n=3 > avail=2 for 3 cycles, then avail=3
    i_fl_avail = 6'd2; i_dec_need = 4'b0111; set_reqs(6'd10, 6'd11, 6'd12, 6'd13);
    settle();
    for (int c = 0; c < 3; c++) begin
      chk("stall_ready", o_dec_ready, 1'b0);
      chk("stall_cnt", o_fl_req_count, 3'd0);
      step();
    end
    i_fl_avail = 6'd3;
    settle();
    chk("unstall_ready", o_dec_ready, 1'b1);
    chk("unstall_cnt", o_fl_req_count, 3'd3);
    push(4'b0111, 6'd10, 6'd11, 6'd12, 6'd0);
    step();
    chk("stall_cycles3", o_stall_cycles, 16'd3);

    // downstream backpressure with a new bundle pending
    i_ren_ready = 1'b0; i_fl_avail = 6'd48; i_dec_need = 4'b0001;
    set_reqs(6'd20, 6'd21, 6'd22, 6'd23);
    settle();
    for (int c = 0; c < 2; c++) begin
      chk("bp_ready", o_dec_ready, 1'b0);
      chk("bp_cnt", o_fl_req_count, 3'd0);
      chk("bp_valid", o_ren_valid, 1'b1);
      chk("bp_mask", o_ren_mask, 4'b0111);
      chk("bp_preg2", o_ren_preg2, 6'd12);
      step();
    end
    i_ren_ready = 1'b1;
    settle();
    chk("bp_release_cnt", o_fl_req_count, 3'd1);
    push(4'b0001, 6'd20, 6'd0, 6'd0, 6'd0);
    step();
    i_dec_valid = 1'b0;
    step();
    chk("idle_valid", o_ren_valid, 1'b0);

    // flush alongside a valid bundle
    i_dec_valid = 1'b1; i_dec_need = 4'b1111; i_flush = 1'b1;
    set_reqs(6'd30, 6'd31, 6'd32, 6'd33);
    settle();
    chk("flush_ready", o_dec_ready, 1'b0);
    chk("flush_cnt", o_fl_req_count, 3'd0);
    step();
    i_flush = 1'b0;
    settle();
    chk("flush_valid", o_ren_valid, 1'b0);
    chk("flushst_ready", o_dec_ready, 1'b0);
    step();
    chk("postflush_cnt", o_fl_req_count, 3'd4);
    push(4'b1111, 6'd30, 6'd31, 6'd32, 6'd33);
    step();

    // zero need with zero avail still passes an empty bundle
    i_fl_avail = 6'd0; i_dec_need = 4'b0000;
    settle();
    chk("zero_ready", o_dec_ready, 1'b1);
    chk("zero_cnt", o_fl_req_count, 3'd0);
    push(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    step();
    i_dec_valid = 1'b0;
    step();

    // reset mid-bundle discards the held output
    i_ren_ready = 1'b0; i_fl_avail = 6'd48; i_dec_valid = 1'b1; i_dec_need = 4'b0011;
    set_reqs(6'd40, 6'd41, 6'd42, 6'd43);
    settle();
    chk("pre_rst_cnt", o_fl_req_count, 3'd2);
    step();
    chk("pre_rst_valid", o_ren_valid, 1'b1);
    i_rst = 1'b1;
    settle();
    chk("rst_mid_cnt", o_fl_req_count, 3'd0);
    chk("rst_mid_ready", o_dec_ready, 1'b0);
    step();
    i_rst = 1'b0; i_ren_ready = 1'b1;
    settle();
    chk("rst_mid_valid", o_ren_valid, 1'b0);
    chk("rst_mid_mask", o_ren_mask, 4'd0);
    chk("rst_mid_stall", o_stall_cycles, 16'd0);

    // long stall to reach saturation
    i_dec_valid = 1'b1; i_dec_need = 4'b0001; i_fl_avail = 6'd0;
    step();
    step();
    repeat (65535) step();
    chk("sat_fffe", o_stall_cycles, 16'hFFFE);
    repeat (3) step();
    chk("sat_ffff", o_stall_cycles, 16'hFFFF);
    chk("sat_ready", o_dec_ready, 1'b0);

    i_dec_valid = 1'b0;
    step();
    step();
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("sb_count", n_popped, n_pushed);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
